// File: rtl/instr_fetch.sv
// -----------------------------------------------------------------------------
// instr_fetch
//   Instruction fetch unit built around a three-state FSM (IDLE, BUSY, HOLD).
//   It issues one memory read per fetch and holds the returned word for the
//   decoder. It freezes the PC block while a fetch is in flight or a word is
//   waiting to be accepted.
//
// Configuration macro:
//   FETCH_TIMEOUT_EN - when defined, a fetch is abandoned after TIMEOUT_CYCLES
//                      BUSY cycles without mem_ack. The abandon drops mem_ren
//                      and pulses fetch_fault. When undefined, BUSY waits
//                      indefinitely.
//
// Ports:
//   clk          in   system clock, rising-edge
//   clr          in   asynchronous active-high reset
//   pc_val       in   [31:0] program counter to fetch from
//   fetch_en     in   request a fetch at pc_val
//   flush        in   discard any in-flight or held instruction
//   mem_addr     out  [31:0] memory read address (registered)
//   mem_ren      out  memory read request, high only in BUSY (registered)
//   mem_rdata    in   [31:0] memory read data, valid with mem_ack
//   mem_ack      in   memory read acknowledge
//   instr        out  [31:0] held instruction word (registered)
//   instr_pc     out  [31:0] address of held instruction (registered)
//   instr_valid  out  instr/instr_pc valid for the decoder (registered)
//   instr_ready  in   decoder accepts instr this cycle
//   pc_stall     out  freezes the PC block (combinational)
//   fetch_fault  out  one-cycle pulse on misalignment or timeout (registered)
// -----------------------------------------------------------------------------
module instr_fetch #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        clr,
    input  logic [31:0] pc_val,
    input  logic        fetch_en,
    input  logic        flush,
    output logic [31:0] mem_addr,
    output logic        mem_ren,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic        pc_stall,
    output logic        fetch_fault
);

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t state_r;
    // A flush seen while the bus transfer is still outstanding; the eventual
    // data is thrown away instead of being presented to the decoder.
    logic   dropped_r;
    logic   aligned_s;

`ifdef FETCH_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] timeout_cnt_r;
`endif

    assign aligned_s = (pc_val[1:0] == 2'b00);

    // Fetch FSM with all registered outputs updated in one place.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_r       <= IDLE;
            dropped_r     <= 1'b0;
            mem_addr      <= 32'd0;
            mem_ren       <= 1'b0;
            instr         <= NOP_INSTR;
            instr_pc      <= 32'd0;
            instr_valid   <= 1'b0;
            fetch_fault   <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
            timeout_cnt_r <= '0;
`endif
        end else begin
            fetch_fault <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (fetch_en) begin
                        if (aligned_s) begin
                            mem_addr  <= pc_val;
                            mem_ren   <= 1'b1;
                            dropped_r <= 1'b0;
                            state_r   <= BUSY;
                        end else begin
                            fetch_fault <= 1'b1;
                        end
                    end else begin
                        mem_ren <= 1'b0;
                    end
                end
                BUSY: begin
                    if (mem_ack) begin
                        mem_ren   <= 1'b0;
                        dropped_r <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
                        timeout_cnt_r <= '0;
`endif
                        if (flush || dropped_r) begin
                            state_r <= IDLE;
                        end else begin
                            instr       <= mem_rdata;
                            instr_pc    <= mem_addr;
                            instr_valid <= 1'b1;
                            state_r     <= HOLD;
                        end
                    end else begin
                        // The transfer cannot be aborted; remember the flush.
                        if (flush) begin
                            dropped_r <= 1'b1;
                        end else begin
                            dropped_r <= dropped_r;
                        end
`ifdef FETCH_TIMEOUT_EN
                        if (timeout_cnt_r == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                            mem_ren       <= 1'b0;
                            fetch_fault   <= 1'b1;
                            dropped_r     <= 1'b0;
                            timeout_cnt_r <= '0;
                            state_r       <= IDLE;
                        end else begin
                            timeout_cnt_r <= timeout_cnt_r + CNT_W'(1);
                        end
`endif
                    end
                end
                HOLD: begin
                    if (flush) begin
                        instr_valid <= 1'b0;
                        state_r     <= IDLE;
                    end else if (instr_ready) begin
                        instr_valid <= 1'b0;
                        if (fetch_en && aligned_s) begin
                            // Back-to-back fetch without passing through IDLE.
                            mem_addr  <= pc_val;
                            mem_ren   <= 1'b1;
                            dropped_r <= 1'b0;
                            state_r   <= BUSY;
                        end else begin
                            fetch_fault <= fetch_en;
                            state_r     <= IDLE;
                        end
                    end else begin
                        state_r <= HOLD;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    mem_ren     <= 1'b0;
                    instr_valid <= 1'b0;
                    dropped_r   <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
                    timeout_cnt_r <= '0;
`endif
                end
            endcase
        end
    end

    // PC freeze: in-flight fetch, or held word not yet accepted.
    always_comb begin
        pc_stall = 1'b0;
        case (state_r)
            BUSY:    pc_stall = 1'b1;
            HOLD:    pc_stall = ~instr_ready;
            default: pc_stall = 1'b0;
        endcase
    end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 16, number of BUSY cycles without mem_ack before a fetch is abandoned (used only with FETCH_TIMEOUT_EN).
REQ-002 clk  input  1  single system clock; all state SHALL update on its rising edge.
REQ-003 clr  input  1  reset, asynchronous, active-high.
REQ-004 pc_val  input  32  current program counter from the PC block.
REQ-005 fetch_en  input  1  request to fetch the instruction at pc_val.
REQ-006 flush  input  1  discard any in-flight or held instruction.
REQ-007 mem_addr  output  32  instruction memory read address.
REQ-008 mem_ren  output  1  memory read request, held until acknowledged.
REQ-009 mem_rdata  input  32  memory read data, valid when mem_ack=1.
REQ-010 mem_ack  input  1  memory read acknowledge.
REQ-011 instr  output  32  fetched instruction word.
REQ-012 instr_pc  output  32  address the held instruction was fetched from.
REQ-013 instr_valid  output  1  instr/instr_pc valid for the decoder.
REQ-014 instr_ready  input  1  decoder accepts instr this cycle.
REQ-015 pc_stall  output  1  drives the PC block's Disable input; freezes pc_val.
REQ-016 fetch_fault  output  1  one-cycle pulse on misaligned address or timeout.

Function
REQ-017 The FSM SHALL have exactly three states: IDLE, BUSY, HOLD.
REQ-018 IDLE: if fetch_en=1 and pc_val[1:0]=00, latch pc_val into mem_addr and go to BUSY next cycle.
REQ-019 IDLE: if fetch_en=1 and pc_val[1:0]!=00, pulse fetch_fault for one cycle, issue no request, stay IDLE.
REQ-020 BUSY: mem_ren=1 and mem_addr stable every cycle until mem_ack=1 is sampled.
REQ-021 BUSY with mem_ack=1 and flush=0: capture mem_rdata into instr and mem_addr into instr_pc, go to HOLD.
REQ-022 BUSY with mem_ack=1 and flush=1: discard data, go to IDLE.
REQ-023 BUSY with flush=1 and mem_ack=0: remain BUSY (the bus transfer cannot be aborted), mark the fetch as dropped, and go to IDLE on mem_ack.
REQ-024 HOLD: instr_valid=1; instr and instr_pc SHALL remain stable until instr_ready=1 or flush=1.
REQ-025 HOLD with instr_ready=1 and flush=0: if fetch_en=1 and pc_val is aligned, latch pc_val and go directly to BUSY (back-to-back); otherwise go to IDLE (misaligned: fetch_fault pulse).
REQ-026 HOLD with flush=1: drop instr_valid next cycle and go to IDLE, regardless of instr_ready.
REQ-027 pc_stall SHALL be combinational: 1 in BUSY, and 1 in HOLD when instr_ready=0; 0 otherwise.
REQ-028 Minimum latency: fetch_en sampled in IDLE at edge N, mem_ren high in cycle N+1, and with mem_ack in that cycle, instr_valid high in cycle N+2.
REQ-029 mem_ack received in IDLE or HOLD SHALL be ignored.
REQ-030 mem_ren SHALL never be asserted outside BUSY.

Reset
REQ-031 On clr=1, immediately (without waiting for clk): state=IDLE, mem_ren=0, mem_addr=0, instr=32'h00000013 (NOP), instr_pc=0, instr_valid=0, fetch_fault=0, and the timeout counter=0.
REQ-032 A reset asserted in BUSY SHALL drop mem_ren asynchronously, and any later mem_ack SHALL be ignored.

Configuration
REQ-033 Macro FETCH_TIMEOUT_EN defined: a counter SHALL increment each BUSY cycle without mem_ack and clear on leaving BUSY; on reaching TIMEOUT_CYCLES the block SHALL deassert mem_ren, pulse fetch_fault, and return to IDLE.
REQ-034 Macro FETCH_TIMEOUT_EN undefined: no counter SHALL be present, BUSY SHALL wait indefinitely, and fetch_fault SHALL arise only from misalignment.

Verification
REQ-035 pc_val=0x100, fetch_en=1, mem_ack returned the first BUSY cycle with rdata=0x00500093 -> mem_addr=0x100; instr=0x00500093, instr_pc=0x100, instr_valid=1 two cycles after fetch_en.
REQ-036 pc_val=0x102, fetch_en=1 -> single-cycle fetch_fault, mem_ren stays 0, state stays IDLE.
REQ-037 Fetch 0x200, instr_ready=0 for 3 cycles, then 1 with fetch_en=1, pc_val=0x204 -> pc_stall high during BUSY and for those 3 cycles; instr stable; mem_ren re-asserts at 0x204 the cycle after acceptance.
REQ-038 flush during BUSY, mem_ack arrives 2 cycles later -> instr_valid never asserted, return to IDLE, instr unchanged.
REQ-039 FETCH_TIMEOUT_EN defined, TIMEOUT_CYCLES=16, no mem_ack -> mem_ren drops after 16 BUSY cycles with a fetch_fault pulse; undefined -> mem_ren stays high for 100+ cycles.
REQ-040 clr=1 mid-BUSY between clock edges -> mem_ren=0 and instr=0x00000013 before the next edge.
